// File: rtl/wfifo_wr_sched.sv
// Write-burst scheduler: drains the write FIFO in fixed-length SDRAM bursts,
// pads underrun beats with DQM, and walks burst addresses through a wrapping region.
module wfifo_wr_sched #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 22,
  parameter int CNT_W     = 8
) (
  input  logic              fifo_rd_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              ref_req,
  input  logic              fifo_empty,
  input  logic [15:0]       fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_data_vld,
  output logic [1:0]        wr_dqm,
  output logic              wr_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W:0]  BURST_STEP = (ADDR_W + 1)'(BURST_LEN);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   addr_sum;
  logic              rd_issued;
  logic              last_beat;

  // One extra bit so a region ending near the top of the address space cannot alias.
  assign addr_sum  = {1'b0, wr_addr} + BURST_STEP;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign busy      = (state != IDLE);

  always_ff @(posedge fifo_rd_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wr_addr   <= '0;
      rd_issued <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      wr_addr   <= addr_nxt;
      rd_issued <= fifo_rd_en;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    addr_nxt     = wr_addr;
    fifo_rd_en   = 1'b0;
    wr_req       = 1'b0;
    wr_data      = '0;
    wr_data_vld  = 1'b0;
    wr_dqm       = 2'b00;
    wr_done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!en)                          addr_nxt  = base_addr;
        else if (!fifo_empty && !ref_req) state_nxt = REQ;
      end
      REQ: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          fifo_rd_en   = !fifo_empty;
          beat_cnt_nxt = '0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        wr_data_vld = 1'b1;
        // A beat carries data only if a read was launched the cycle before.
        if (rd_issued) wr_data = fifo_rd_data;
        else           wr_dqm  = 2'b11;
        fifo_rd_en   = !fifo_empty && !last_beat;
        beat_cnt_nxt = beat_cnt + CNT_W'(1);
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        wr_done   = 1'b1;
        addr_nxt  = (addr_sum > {1'b0, end_addr}) ? base_addr : addr_sum[ADDR_W-1:0];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may be pulled from the FIFO in a cycle that is being reset.
    if (!rst_n) fifo_rd_en = 1'b0;
  end

endmodule

// File: tb/tb_wfifo_wr_sched.sv
// Bench for wfifo_wr_sched: FIFO + sequencer stand-ins, a burst-level expectation queue
// checked every cycle, and directed scenarios with literal expectations.
module tb_wfifo_wr_sched;
  localparam int BL = 8;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst_n, en, ref_req, wr_ack;
  logic [AW-1:0] base_addr, end_addr;
  logic          fifo_empty, fifo_rd_en, wr_req, wr_data_vld, wr_done, busy;
  logic [15:0]   fifo_rd_data, wr_data;
  logic [1:0]    wr_dqm;
  logic [AW-1:0] wr_addr;

  wfifo_wr_sched #(.BURST_LEN(BL), .ADDR_W(AW), .CNT_W(8)) dut (
    .fifo_rd_clk(clk), .rst_n(rst_n), .en(en), .base_addr(base_addr), .end_addr(end_addr),
    .ref_req(ref_req), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_data_vld(wr_data_vld), .wr_dqm(wr_dqm), .wr_done(wr_done),
    .busy(busy));

  always #5 clk = ~clk;

  // FIFO stand-in: words are written by the stimulus, read one cycle late on fifo_rd_en.
  logic [15:0] mem [64];
  logic [6:0]  wr_ptr = '0;
  logic [6:0]  rd_ptr = '0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk)
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 7'd1;
    end

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  dqm;
    logic        done;
    logic        rd_ok;
  } beat_t;

  int            tests = 0, fails = 0;
  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr;
  logic          req_prev, ack_prev, last_idle, start_ok;
  int            burst_n, burst_rd, rd_total, done_cnt;
  logic [15:0]   beat_log[$];
  logic [1:0]    dqm_log[$];
  logic [AW-1:0] addr_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle model: a burst, once acked, is BL beats (first min(BL,fill) real,
  // the rest padded) followed by one done cycle.
  task automatic monitor();
    beat_t       e;
    logic        in_burst, idle_now, exp_req, exp_rd;
    logic [AW:0] nxt;
    logic [6:0]  idx;
    int          n;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rd_en_in_reset", fifo_rd_en, 1'b0);
        exp_q.delete();
        exp_addr = '0; req_prev = 0; ack_prev = 0; last_idle = 0; start_ok = 0;
      end else begin
        in_burst = (exp_q.size() > 0);
        idle_now = !wr_req && !in_burst;
        exp_req  = (req_prev && !ack_prev) || (last_idle && start_ok);
        chk("wr_req", wr_req, exp_req);
        chk("busy", busy, wr_req || in_burst);
        if (wr_req) begin
          chk("wr_addr", wr_addr, exp_addr);
          if (!req_prev) addr_log.push_back(wr_addr);
        end
        exp_rd = !fifo_empty && ((wr_req && wr_ack) || (in_burst && exp_q[0].rd_ok));
        if (wr_req && wr_ack) begin
          n = int'(7'(wr_ptr - rd_ptr));
          if (n > BL) n = BL;
          burst_n = n; burst_rd = 0;
          for (int k = 0; k < BL; k++) begin
            idx     = rd_ptr + 7'(k);
            e.data  = (k < n) ? mem[idx[5:0]] : 16'h0;
            e.dqm   = (k < n) ? 2'b00 : 2'b11;
            e.done  = 1'b0;
            e.rd_ok = (k < BL - 1);
            exp_q.push_back(e);
          end
          e = '0; e.done = 1'b1;
          exp_q.push_back(e);
        end
        chk("fifo_rd_en", fifo_rd_en, exp_rd);
        if (fifo_rd_en) begin burst_rd++; rd_total++; end
        if (in_burst) begin
          e = exp_q.pop_front();
          chk("wr_data_vld", wr_data_vld, !e.done);
          chk("wr_done", wr_done, e.done);
          chk("wr_data", wr_data, e.data);
          chk("wr_dqm", wr_dqm, e.dqm);
          if (wr_data_vld) begin beat_log.push_back(wr_data); dqm_log.push_back(wr_dqm); end
          if (e.done) begin
            chk("reads_per_burst", burst_rd, burst_n);
            done_cnt++;
            nxt      = {1'b0, exp_addr} + (AW + 1)'(BL);
            exp_addr = (nxt > {1'b0, end_addr}) ? base_addr : nxt[AW-1:0];
          end
        end else begin
          chk("idle_vld", wr_data_vld, 1'b0);
          chk("idle_done", wr_done, 1'b0);
          chk("idle_data", wr_data, 16'h0);
          chk("idle_dqm", wr_dqm, 2'b00);
        end
        if (idle_now && !en) exp_addr = base_addr;
        start_ok  = idle_now && en && !fifo_empty && !ref_req;
        last_idle = idle_now;
        req_prev  = wr_req;
        ack_prev  = wr_req && wr_ack;
      end
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 7'd1;
  endtask

  task automatic do_ack(input int dly);
    int t = 0;
    while (wr_req !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    chk("req_wait", wr_req, 1'b1);
    repeat (dly) begin @(posedge clk); #1; end
    wr_ack = 1'b1;
    @(posedge clk); #1;
    wr_ack = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("idle_wait", busy, 1'b0);
  endtask

  initial begin
    int cnt, snap;
    rd_total = 0; done_cnt = 0; burst_n = 0; burst_rd = 0;
    rst_n = 0; en = 0; ref_req = 0; wr_ack = 0;
    base_addr = 22'h10; end_addr = 22'h3F;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_wr_addr", wr_addr, 22'h0);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vld", wr_data_vld, 1'b0);
    chk("rst_dqm", wr_dqm, 2'b00);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    @(posedge clk); #1;

    // 1: sixteen words -> two full bursts at base and base+8
    for (int i = 1; i <= 16; i++) push(16'(i));
    en = 1;
    beat_log.delete(); dqm_log.delete(); addr_log.delete(); snap = done_cnt;
    do_ack(2); do_ack(2); wait_idle();
    chk("t1_nbeats", beat_log.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk("t1_beat", beat_log[k], 32'(k + 1));
      chk("t1_dqm", dqm_log[k], 2'b00);
    end
    chk("t1_addr0", addr_log[0], 22'h10);
    chk("t1_addr1", addr_log[1], 22'h18);
    chk("t1_dones", done_cnt - snap, 2);

    // 2: underrun after three words -> five padded beats
    beat_log.delete(); dqm_log.delete(); snap = rd_total;
    push(16'h00A1); push(16'h00A2); push(16'h00A3);
    do_ack(1); wait_idle();
    chk("t2_nbeats", beat_log.size(), BL);
    chk("t2_b0", beat_log[0], 16'h00A1);
    chk("t2_b1", beat_log[1], 16'h00A2);
    chk("t2_b2", beat_log[2], 16'h00A3);
    for (int k = 3; k < BL; k++) begin
      chk("t2_pad", beat_log[k], 16'h0);
      chk("t2_pad_dqm", dqm_log[k], 2'b11);
    end
    chk("t2_reads", rd_total - snap, 3);

    // 3: region 0..23 wraps after the third burst
    en = 0; base_addr = '0; end_addr = 22'd23;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) push(16'h3000 + 16'(i));
    en = 1; addr_log.delete();
    do_ack(0); do_ack(1); do_ack(3); do_ack(2); wait_idle();
    chk("t3_n", addr_log.size(), 4);
    chk("t3_a0", addr_log[0], 22'd0);
    chk("t3_a1", addr_log[1], 22'd8);
    chk("t3_a2", addr_log[2], 22'd16);
    chk("t3_a3", addr_log[3], 22'd0);

    // 4: refresh blocks a new burst but never withdraws a pending request
    ref_req = 1;
    for (int i = 0; i < 8; i++) push(16'h4000 + 16'(i));
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (wr_req) cnt++; end
    chk("t4_blocked", cnt, 0);
    ref_req = 0;
    do begin @(posedge clk); #1; cnt++; end while (wr_req !== 1'b1 && cnt < 100);
    ref_req = 1; en = 0; cnt = 0;
    repeat (4) begin @(posedge clk); #1; if (wr_req) cnt++; end
    chk("t4_held", cnt, 4);
    do_ack(0); wait_idle();

    // 5: reset at beat 3 aborts the burst without wr_done
    base_addr = 22'h40; end_addr = 22'h7F; ref_req = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push(16'h5000 + 16'(i));
    en = 1;
    do_ack(2);
    repeat (3) @(posedge clk);
    #1 rst_n = 0; ref_req = 1; snap = done_cnt;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("t5_vld", wr_data_vld, 1'b0);
    chk("t5_rd_en", fifo_rd_en, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_addr", wr_addr, 22'h0);
    repeat (6) @(posedge clk);
    #1 chk("t5_no_done", done_cnt - snap, 0);
    addr_log.delete(); beat_log.delete();
    ref_req = 0;
    do_ack(1); wait_idle();
    chk("t5_restart_addr", addr_log[0], 22'h0);
    chk("t5_left0", beat_log[0], 16'h5004);

    // 6: base reloads while disabled
    en = 0; base_addr = 22'h100; end_addr = 22'h1FF;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) push(16'h6000 + 16'(i));
    en = 1; cnt = 0;
    while (wr_req !== 1'b1 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    chk("t6_addr", wr_addr, 22'h100);
    do_ack(1); wait_idle();

    en = 0;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
